fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controller that drives the program counter's next-PC input and sequences instruction fetch through a variable-latency req/ack instruction-memory port.
- Picks the next PC from sequential, jump, branch or exception sources, and holds the PC during stalls and outstanding fetches.
- Sits between program_counter (pc_in/pc_out), instruction memory and the decode stage. program_counter loads pc_in every clock, so "hold" means driving pc_next = pc_out.

Parameters:
- RESET_VECTOR, 32'h00400000, PC value driven on pc_next while reset is high.
- EXC_VECTOR, 32'h80000180, redirect target on exception.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_out  in  32  current PC from program_counter.
- pc_next  out  32  next PC; drives program_counter pc_in (combinational).
- stall  in  1  decode stage cannot accept an instruction this cycle.
- branch_taken  in  1  branch redirect request.
- branch_target  in  32  branch target.
- jump  in  1  jump redirect request.
- jump_target  in  32  jump target.
- exception  in  1  exception redirect request.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  registered fetch address, stable while imem_req is high.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr_out/instr_pc valid for decode.
- instr_out  out  32  fetched instruction (registered).
- instr_pc  out  32  address of instr_out (registered).

Behaviour:
- Reset (sync, high):
  - state=IDLE; imem_req=0; imem_addr=0; instr_valid=0; instr_out=0; instr_pc=0.
  - pc_next=RESET_VECTOR while reset is high.
  - Reset mid-fetch abandons the outstanding request: imem_req low the next cycle, no data retained.
- Redirect priority: exception > branch_taken > jump. Target = EXC_VECTOR, branch_target or jump_target. Target bits[1:0] are forced to 0.
- Sequential next PC = pc_out + 4, modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
- Default: pc_next = pc_out (hold).
- IDLE: imem_req=0. Next cycle -> FETCH, latching imem_addr=pc_out.
- FETCH: imem_req=1.
  - ack & redirect: rdata discarded; pc_next=target; stay FETCH; imem_addr reloads with the new PC next cycle.
  - ack & !redirect & !stall: next cycle instr_valid=1, instr_out=rdata, instr_pc=imem_addr. pc_next=pc_out+4. Stay FETCH with the new address. Back-to-back: one instruction per cycle with 0-wait memory.
  - ack & !redirect & stall: rdata/addr captured into hold buffer; -> HOLD; pc_next=pc_out.
  - !ack & redirect: pc_next=target; -> DRAIN (the request must complete).
  - !ack & !redirect: hold.
- HOLD: imem_req=0; instr_valid=1 with the buffered word.
  - redirect: buffer dropped; pc_next=target; -> FETCH; instr_valid=0 next cycle.
  - !stall: instruction consumed this cycle; pc_next=pc_out+4; -> FETCH.
- DRAIN: imem_req=1 at the old imem_addr.
  - A further redirect updates pc_next to the new target; the latest target wins.
  - ack: data discarded, instr_valid stays 0; -> FETCH at pc_out.
- instr_valid is never high in DRAIN or IDLE. It is high for exactly one cycle per accepted non-stalled fetch.
- Simultaneous stall and redirect: redirect wins.
- imem_addr only changes when imem_req is low or in the cycle after an ack.

Decomposition:
- Shared package:
  - state enum {IDLE, FETCH, HOLD, DRAIN} (2-bit encoding);
  - RESET_VECTOR/EXC_VECTOR defaults;
  - PC_INCR=4.
- Sub-module next_pc_mux (combinational priority select plus +4 adder, bit[1:0] clear). Used by fetch_sequencer; unit-testable alone.

Test Plan:
- Reset then 0-wait memory, ack every cycle: pc_next 00400000 -> 00400004 -> 00400008. instr_valid every cycle from cycle 2; instr_pc 00400000, 00400004.
- 3-cycle ack latency: imem_req high for 3 cycles at imem_addr=00400004, pc_next held at 00400004; one instr_valid pulse after ack.
- stall high at ack for 2 cycles: HOLD, instr_valid high 2 cycles, pc_out held. Stall low: pc_next=pc_out+4.
- branch_taken with branch_target=00400103 during outstanding fetch: pc_next=00400100; DRAIN discards the old ack (no instr_valid); next imem_addr=00400100.
- exception, branch_taken and jump asserted together: pc_next=80000180. pc_out=FFFFFFFC sequential: pc_next=00000000.
- reset asserted mid-WAIT: next cycle imem_req=0, instr_valid=0, pc_next=00400000; a late ack is ignored.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its next-PC mux.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;
    localparam logic [31:0] PC_INCR          = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_mux.sv
// Next-PC source select: exception > branch > jump redirect, plus the sequential +4 path.
module next_pc_mux
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [31:0] pc_out,
    input  logic        exception,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        redirect,
    output logic [31:0] redirect_target,
    output logic [31:0] seq_pc
);

    assign redirect = exception | branch_taken | jump;
    assign seq_pc   = pc_out + PC_INCR;

    always_comb begin
        redirect_target = word_align(jump_target);
        if (exception) begin
            redirect_target = word_align(EXC_VECTOR);
        end else if (branch_taken) begin
            redirect_target = word_align(branch_target);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: steers program_counter via pc_next and runs req/ack fetches into decode.
//   state | meaning
//   IDLE  | after reset; latch first fetch address from pc_out
//   FETCH | request outstanding at imem_addr
//   HOLD  | fetched word parked for a stalled decode stage
//   DRAIN | redirected mid-fetch; waiting to discard the old ack
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_out,
    output logic [31:0] pc_next,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
);

    state_t      state, state_nx;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] seq_pc;
    logic        load_addr;
    logic        capture;
    logic        valid_nx;
    logic [31:0] addr_nx;

    next_pc_mux #(.EXC_VECTOR(EXC_VECTOR)) u_next_pc_mux (
        .pc_out          (pc_out),
        .exception       (exception),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .seq_pc          (seq_pc)
    );

    always_comb begin
        state_nx  = state;
        pc_next   = pc_out;
        imem_req  = 1'b0;
        load_addr = 1'b0;
        capture   = 1'b0;
        valid_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                state_nx  = FETCH;
                load_addr = 1'b1;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    load_addr = 1'b1;
                    if (redirect) begin
                        pc_next = redirect_target;
                    end else begin
                        capture  = 1'b1;
                        valid_nx = 1'b1;
                        if (stall) begin
                            state_nx = HOLD;
                        end else begin
                            pc_next = seq_pc;
                        end
                    end
                end else if (redirect) begin
                    pc_next  = redirect_target;
                    state_nx = DRAIN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next   = redirect_target;
                    state_nx  = FETCH;
                    load_addr = 1'b1;
                end else if (!stall) begin
                    pc_next   = seq_pc;
                    state_nx  = FETCH;
                    load_addr = 1'b1;
                end else begin
                    valid_nx = 1'b1;
                end
            end
            DRAIN: begin
                // the old request must still see its ack; only the PC follows redirects
                imem_req = 1'b1;
                if (redirect) begin
                    pc_next = redirect_target;
                end
                if (imem_ack) begin
                    state_nx  = FETCH;
                    load_addr = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // pc_next is what pc_out becomes, so it is also the next fetch address
        addr_nx = load_addr ? pc_next : imem_addr;
        if (reset) begin
            pc_next = RESET_VECTOR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_nx;
            imem_addr   <= addr_nx;
            instr_valid <= valid_nx;
            if (capture) begin
                instr_out <= imem_rdata;
                instr_pc  <= imem_addr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer against a program-flow reference model.
module tb_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] EV = 32'h8000_0180;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_out = '0;
    logic [31:0] pc_next;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        exception = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    fetch_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .pc_out        (pc_out),
        .pc_next       (pc_next),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exception     (exception),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc)
    );

    always #5 clock = ~clock;

    // program_counter: loads pc_next every clock
    always @(posedge clock) pc_out <= pc_next;

    int n_cmp = 0;
    int n_bad = 0;
    int n_deliv = 0;

    logic [63:0] exp_q[$];
    logic        exp_hold = 1'b0;
    logic [31:0] hold_pc = '0;
    logic [31:0] hold_data = '0;

    logic [31:0] flow_pc = RV;
    logic [31:0] cur_addr = '0;
    logic        req_active = 1'b0;
    logic        squash = 1'b0;
    logic        post_reset = 1'b0;
    logic        last_reset = 1'b0;
    logic        mem_busy = 1'b0;
    int          mem_wait = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        case ($urandom_range(0, 3))
            0: t = 32'hFFFF_FFFC;
            1: t = 32'h0040_0103;
            default: ;
        endcase
        return t;
    endfunction

    // monitor: compares what decode sees against the scoreboard
    initial begin
        logic [63:0] e;
        @(posedge clock);
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("valid_new", {31'd0, instr_valid}, 32'd1);
                chk("instr_pc", instr_pc, e[63:32]);
                chk("instr_out", instr_out, e[31:0]);
            end else if (exp_hold) begin
                chk("valid_hold", {31'd0, instr_valid}, 32'd1);
                chk("hold_pc", instr_pc, hold_pc);
                chk("hold_data", instr_out, hold_data);
                chk("hold_req", {31'd0, imem_req}, 32'd0);
            end else begin
                chk("valid_idle", {31'd0, instr_valid}, 32'd0);
            end
        end
    end

    task automatic run_cycle(input int maxw, input int stall_pct, input int redir_pct,
                             input bit do_reset);
        logic        was_reset;
        logic        redirect;
        logic [31:0] tgt;
        logic [2:0]  sel;
        @(posedge clock);
        #1;
        was_reset  = last_reset;
        last_reset = do_reset;
        reset = do_reset;
        stall = ($urandom_range(0, 99) < stall_pct);
        exception = 1'b0;
        branch_taken = 1'b0;
        jump = 1'b0;
        branch_target = rand_target();
        jump_target = rand_target();
        if (!was_reset && !do_reset && ($urandom_range(0, 99) < redir_pct)) begin
            sel = 3'($urandom_range(1, 7));
            exception = sel[0];
            branch_taken = sel[1];
            jump = sel[2];
        end
        imem_rdata = $urandom;
        if (was_reset) begin
            imem_ack = 1'b1;
        end else if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = int'($urandom_range(0, maxw));
            end
            if (mem_wait == 0) begin
                imem_ack = 1'b1;
                mem_busy = 1'b0;
            end else begin
                imem_ack = 1'b0;
                mem_wait--;
            end
        end else begin
            imem_ack = 1'b0;
        end
        if (do_reset) mem_busy = 1'b0;

        @(negedge clock);
        #1;
        if (reset) begin
            chk("pc_reset", pc_next, RV);
            exp_q.delete();
            exp_hold = 1'b0;
            req_active = 1'b0;
            squash = 1'b0;
            flow_pc = RV;
            post_reset = 1'b1;
        end else begin
            if (post_reset) begin
                chk("req_after_reset", {31'd0, imem_req}, 32'd0);
                post_reset = 1'b0;
            end
            redirect = exception | branch_taken | jump;
            tgt = exception ? EV : (branch_taken ? {branch_target[31:2], 2'b00}
                                                 : {jump_target[31:2], 2'b00});
            if (imem_req) begin
                if (!req_active) begin
                    req_active = 1'b1;
                    squash = 1'b0;
                    cur_addr = imem_addr;
                    chk("fetch_addr", imem_addr, flow_pc);
                end else begin
                    chk("addr_stable", imem_addr, cur_addr);
                end
                if (redirect) squash = 1'b1;
                if (!redirect && squash) chk("pc_drain", pc_next, flow_pc);
                if (imem_ack) begin
                    req_active = 1'b0;
                    if (!squash) begin
                        exp_q.push_back({cur_addr, imem_rdata});
                        n_deliv++;
                        flow_pc = cur_addr + 32'd4;
                        if (stall) begin
                            exp_hold = 1'b1;
                            hold_pc = cur_addr;
                            hold_data = imem_rdata;
                            chk("pc_stall_ack", pc_next, cur_addr);
                        end else begin
                            chk("pc_seq", pc_next, cur_addr + 32'd4);
                        end
                    end
                end else if (!squash) begin
                    chk("pc_wait", pc_next, cur_addr);
                end
            end else if (exp_hold) begin
                if (redirect) begin
                    exp_hold = 1'b0;
                end else if (!stall) begin
                    exp_hold = 1'b0;
                    chk("pc_release", pc_next, hold_pc + 32'd4);
                end else begin
                    chk("pc_held", pc_next, hold_pc);
                end
            end
            if (redirect) begin
                flow_pc = tgt;
                chk("pc_redirect", pc_next, tgt);
            end
        end
    endtask

    initial begin
        // {max wait, stall %, redirect %, reset per mille, cycles}
        int phases[6][5] = '{
            '{0,  0,  0,  0,  20},
            '{3,  0,  0,  0,  40},
            '{1, 40,  0,  0,  80},
            '{3,  0, 25,  0,  80},
            '{2, 30, 20,  0, 200},
            '{3, 30, 20, 30, 400}
        };
        reset = 1'b1;
        run_cycle(0, 0, 0, 1'b1);
        run_cycle(0, 0, 0, 1'b1);
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < phases[p][4]; c++) begin
                run_cycle(phases[p][0], phases[p][1], phases[p][2],
                          (c == 0) || ($urandom_range(0, 999) < phases[p][3]));
            end
        end
        run_cycle(0, 0, 0, 1'b0);
        chk("enough_deliveries", {31'd0, n_deliv > 50}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
